// File: rtl/flash_pkg.sv
// flash_pkg: definitions shared by the DE2-115 parallel NOR flash read path.
//   FLASH_ADDR_W  - flash byte address width (8 MB device); the ROM loader uses it too
//   FLASH_DQ_W    - flash data bus width (byte mode)
//   flash_state_t - sequencing states of flash_word_reader
//   max3()        - constant helper for sizing the shared down-counter
package flash_pkg;

  localparam int unsigned FLASH_ADDR_W = 23;
  localparam int unsigned FLASH_DQ_W   = 8;

  typedef enum logic [2:0] {
    RST_PULSE,
    RST_WAIT,
    IDLE,
    RD_HI,
    RD_LO,
    DONE
  } flash_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/flash_word_reader.sv
// flash_word_reader: serves toggle-handshake 16-bit word reads from the 8-bit
// parallel NOR flash by issuing two byte reads (even address, then odd).
// After system reset it pulses the flash reset pin and waits for recovery.
// The flash is never written: WE# is tied high and WP# tied low.
//
// Ports:
//   iclk, ireset      clock; synchronous active-high reset
//   iaddr             word-aligned byte address, bit 0 ignored, sampled at acceptance
//   ireq / oack       toggle handshake; a request is pending while ireq != oack
//   odata             assembled word, valid from the oack toggle to the next one
//   obusy             high in every state except IDLE (including the reset sequence)
//   ofl_addr, ifl_dq  flash byte address / data bus
//   ofl_ce_n, ofl_oe_n, ofl_we_n, ofl_rst_n, ofl_wp_n   flash control pins
//
// Parameters:
//   ACCESS_CYCLES  cycles per byte read with CE#/OE# low and address stable (>= 1)
//   RST_CYCLES     cycles ofl_rst_n is held low after ireset falls (>= 1)
//   RST_RECOVER    cycles after ofl_rst_n rises before the first access (>= 1)
//   BIG_ENDIAN     1: odata = {byte[A], byte[A+1]}; 0: {byte[A+1], byte[A]}
module flash_word_reader
  import flash_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 6,
  parameter int unsigned RST_CYCLES    = 32,
  parameter int unsigned RST_RECOVER   = 16,
  parameter bit          BIG_ENDIAN    = 1'b1
) (
  input  logic                    iclk,
  input  logic                    ireset,
  input  logic [FLASH_ADDR_W-1:0] iaddr,
  input  logic                    ireq,
  output logic                    oack,
  output logic [15:0]             odata,
  output logic                    obusy,
  output logic [FLASH_ADDR_W-1:0] ofl_addr,
  input  logic [FLASH_DQ_W-1:0]   ifl_dq,
  output logic                    ofl_ce_n,
  output logic                    ofl_oe_n,
  output logic                    ofl_we_n,
  output logic                    ofl_rst_n,
  output logic                    ofl_wp_n
);

  localparam int unsigned CNT_MAX = max3(ACCESS_CYCLES, RST_CYCLES, RST_RECOVER);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // The counter is loaded with N-1 on entry and the state exits when it reads 0,
  // so each timed state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RCV_LOAD = CNT_W'(RST_RECOVER - 1);

  flash_state_t                state, state_n;
  logic [CNT_W-1:0]            cnt, cnt_n;
  logic [FLASH_DQ_W-1:0]       byte_even, byte_even_n;
  logic [FLASH_DQ_W-1:0]       byte_odd, byte_odd_n;
  logic [FLASH_ADDR_W-1:0]     addr_n;
  logic [15:0]                 data_n;
  logic                        ack_n, busy_n, ce_n_n, oe_n_n, rst_n_n;

  assign ofl_we_n = 1'b1;
  assign ofl_wp_n = 1'b0;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state     <= RST_PULSE;
      cnt       <= RST_LOAD;
      byte_even <= '0;
      byte_odd  <= '0;
      ofl_addr  <= '0;
      odata     <= '0;
      oack      <= 1'b0;
      obusy     <= 1'b1;
      ofl_ce_n  <= 1'b1;
      ofl_oe_n  <= 1'b1;
      ofl_rst_n <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      byte_even <= byte_even_n;
      byte_odd  <= byte_odd_n;
      ofl_addr  <= addr_n;
      odata     <= data_n;
      oack      <= ack_n;
      obusy     <= busy_n;
      ofl_ce_n  <= ce_n_n;
      ofl_oe_n  <= oe_n_n;
      ofl_rst_n <= rst_n_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    byte_even_n = byte_even;
    byte_odd_n  = byte_odd;
    addr_n      = ofl_addr;
    data_n      = odata;
    ack_n       = oack;
    busy_n      = obusy;
    ce_n_n      = ofl_ce_n;
    oe_n_n      = ofl_oe_n;
    rst_n_n     = ofl_rst_n;

    unique case (state)
      RST_PULSE: begin
        if (cnt == '0) begin
          state_n = RST_WAIT;
          cnt_n   = RCV_LOAD;
          rst_n_n = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      RST_WAIT: begin
        if (cnt == '0) begin
          state_n = IDLE;
          cnt_n   = '0;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      IDLE: begin
        if (ireq != oack) begin
          // ofl_addr[22:1] doubles as the latched word address for the access.
          addr_n    = iaddr;
          addr_n[0] = 1'b0;
          ce_n_n    = 1'b0;
          oe_n_n    = 1'b0;
          busy_n    = 1'b1;
          cnt_n     = ACC_LOAD;
          state_n   = RD_HI;
        end
      end

      RD_HI: begin
        if (cnt == '0) begin
          // CE#/OE# stay asserted; only A0 changes for the second byte.
          byte_even_n = ifl_dq;
          addr_n[0]   = 1'b1;
          cnt_n       = ACC_LOAD;
          state_n     = RD_LO;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      RD_LO: begin
        if (cnt == '0) begin
          byte_odd_n = ifl_dq;
          cnt_n      = '0;
          state_n    = DONE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      DONE: begin
        data_n  = BIG_ENDIAN ? {byte_even, byte_odd} : {byte_odd, byte_even};
        ack_n   = ~oack;
        ce_n_n  = 1'b1;
        oe_n_n  = 1'b1;
        busy_n  = 1'b0;
        cnt_n   = '0;
        state_n = IDLE;
      end

      default: begin
        // Unreachable encodings restart the flash reset sequence.
        state_n = RST_PULSE;
        cnt_n   = RST_LOAD;
        ce_n_n  = 1'b1;
        oe_n_n  = 1'b1;
        rst_n_n = 1'b0;
        busy_n  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_flash_word_reader.sv
// tb_flash_word_reader: directed bench for flash_word_reader with a byte-wide
// flash model of 4-cycle read latency. A second instance with BIG_ENDIAN=0 runs
// in lockstep on the same inputs and flash data to check the swapped word order.
module tb_flash_word_reader;
  import flash_pkg::*;

  localparam int unsigned AC     = 4;
  localparam int unsigned RC     = 8;
  localparam int unsigned RR     = 4;
  localparam int unsigned FL_LAT = 4;
  localparam int          LAT    = 2 * AC + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [22:0] addr;
  logic        req;
  logic [7:0]  dq;

  logic        ack, busy, ce_n, oe_n, we_n, rst_n, wp_n;
  logic [15:0] data;
  logic [22:0] fl_addr;

  logic        ack_le, busy_le, ce_n_le, oe_n_le, we_n_le, rst_n_le, wp_n_le;
  logic [15:0] data_le;
  logic [22:0] fl_addr_le;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit tie_bad = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  flash_word_reader #(
    .ACCESS_CYCLES(AC), .RST_CYCLES(RC), .RST_RECOVER(RR), .BIG_ENDIAN(1'b1)
  ) dut (
    .iclk(clk), .ireset(rst), .iaddr(addr), .ireq(req), .oack(ack), .odata(data),
    .obusy(busy), .ofl_addr(fl_addr), .ifl_dq(dq), .ofl_ce_n(ce_n), .ofl_oe_n(oe_n),
    .ofl_we_n(we_n), .ofl_rst_n(rst_n), .ofl_wp_n(wp_n)
  );

  flash_word_reader #(
    .ACCESS_CYCLES(AC), .RST_CYCLES(RC), .RST_RECOVER(RR), .BIG_ENDIAN(1'b0)
  ) dut_le (
    .iclk(clk), .ireset(rst), .iaddr(addr), .ireq(req), .oack(ack_le), .odata(data_le),
    .obusy(busy_le), .ofl_addr(fl_addr_le), .ifl_dq(dq), .ofl_ce_n(ce_n_le),
    .ofl_oe_n(oe_n_le), .ofl_we_n(we_n_le), .ofl_rst_n(rst_n_le), .ofl_wp_n(wp_n_le)
  );

  // Flash contents: four fixed bytes, everything else a simple address pattern.
  function automatic logic [7:0] flash_byte(input logic [22:0] a);
    case (a)
      23'h000000: return 8'h12;
      23'h000001: return 8'h34;
      23'h7FFFFE: return 8'hAB;
      23'h7FFFFF: return 8'hCD;
      default:    return a[7:0] ^ {a[14:8], 1'b1} ^ 8'h5A;
    endcase
  endfunction

  // age = full cycles the bus has been stable as seen at the next edge, minus one;
  // data is valid only after FL_LAT stable cycles, otherwise the inverted byte.
  logic [24:0] last_bus = '0;
  int          age = 0;
  always @(posedge clk) begin
    if ({ce_n, oe_n, fl_addr} != last_bus) age <= 1;
    else age <= age + 1;
    last_bus <= {ce_n, oe_n, fl_addr};
  end
  assign dq = (ce_n == 1'b0 && oe_n == 1'b0 && age >= int'(FL_LAT) - 1)
              ? flash_byte(fl_addr) : ~flash_byte(fl_addr);

  always @(negedge clk) begin
    if (we_n !== 1'b1 || wp_n !== 1'b0 || we_n_le !== 1'b1 || wp_n_le !== 1'b0)
      tie_bad = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 1'b0;
    addr = '0;
    tick();
    tick();
    total++; if (ack !== 1'b0)      begin bad++; $display("FAIL rst_ack got=%0b exp=0", ack); end
    total++; if (data !== 16'h0)    begin bad++; $display("FAIL rst_data got=%h exp=0000", data); end
    total++; if (fl_addr !== 23'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", fl_addr); end
    total++; if (ce_n !== 1'b1 || oe_n !== 1'b1)
      begin bad++; $display("FAIL rst_ce_oe got=%0b%0b exp=11", ce_n, oe_n); end
    total++; if (rst_n !== 1'b0)    begin bad++; $display("FAIL rst_fl_rst got=%0b exp=0", rst_n); end
    total++; if (busy !== 1'b1)     begin bad++; $display("FAIL rst_busy got=%0b exp=1", busy); end
    total++; if (we_n !== 1'b1 || wp_n !== 1'b0)
      begin bad++; $display("FAIL rst_ties got we=%0b wp=%0b exp we=1 wp=0", we_n, wp_n); end
    rst = 1'b0;
    // c counts edges after the last edge that sampled ireset high.
    for (int c = 1; c <= 16; c++) begin
      logic exp_rstn, exp_busy;
      tick();
      exp_rstn = (c >= int'(RC));
      exp_busy = (c < int'(RC + RR));
      total++; if (rst_n !== exp_rstn)
        begin bad++; $display("FAIL rel_fl_rst c=%0d got=%0b exp=%0b", c, rst_n, exp_rstn); end
      total++; if (busy !== exp_busy)
        begin bad++; $display("FAIL rel_busy c=%0d got=%0b exp=%0b", c, busy, exp_busy); end
      total++; if (ce_n !== 1'b1 || ack !== 1'b0)
        begin bad++; $display("FAIL rel_ce_ack c=%0d got ce=%0b ack=%0b exp ce=1 ack=0", c, ce_n, ack); end
    end
  endtask

  task automatic test_basic_read();
    logic [22:0] exp_a;
    addr = 23'h000000;
    req  = ~req;
    for (int c = 1; c <= LAT; c++) begin
      tick();
      if (c == 2) addr = 23'h555554;
      if (c <= int'(AC)) begin
        exp_a = 23'h000000;
        total++; if (fl_addr !== exp_a || ce_n !== 1'b0 || oe_n !== 1'b0)
          begin bad++; $display("FAIL rd_even c=%0d got a=%h ce=%0b oe=%0b exp a=%h ce=0 oe=0", c, fl_addr, ce_n, oe_n, exp_a); end
      end else if (c < LAT) begin
        exp_a = 23'h000001;
        total++; if (fl_addr !== exp_a || ce_n !== 1'b0 || oe_n !== 1'b0)
          begin bad++; $display("FAIL rd_odd c=%0d got a=%h ce=%0b oe=%0b exp a=%h ce=0 oe=0", c, fl_addr, ce_n, oe_n, exp_a); end
      end
      if (c < LAT) begin
        total++; if (ack === req)
          begin bad++; $display("FAIL rd_early_ack c=%0d got=%0b exp=%0b", c, ack, ~req); end
      end
    end
    total++; if (ack !== req)        begin bad++; $display("FAIL rd_ack got=%0b exp=%0b", ack, req); end
    total++; if (data !== 16'h1234)  begin bad++; $display("FAIL rd_data got=%h exp=1234", data); end
    total++; if (data_le !== 16'h3412) begin bad++; $display("FAIL rd_data_le got=%h exp=3412", data_le); end
    total++; if (ce_n !== 1'b1 || oe_n !== 1'b1 || busy !== 1'b0)
      begin bad++; $display("FAIL rd_end got ce=%0b oe=%0b busy=%0b exp 1 1 0", ce_n, oe_n, busy); end
    tick();
  endtask

  task automatic test_odd_addr();
    addr = 23'h7FFFFF;
    req  = ~req;
    for (int c = 1; c <= LAT; c++) begin
      tick();
      if (c == 1) begin
        total++; if (fl_addr !== 23'h7FFFFE)
          begin bad++; $display("FAIL odd_even_addr got=%h exp=7ffffe", fl_addr); end
      end
      if (c == int'(AC) + 1) begin
        total++; if (fl_addr !== 23'h7FFFFF)
          begin bad++; $display("FAIL odd_odd_addr got=%h exp=7fffff", fl_addr); end
      end
    end
    total++; if (ack !== req)          begin bad++; $display("FAIL odd_ack got=%0b exp=%0b", ack, req); end
    total++; if (data !== 16'hABCD)    begin bad++; $display("FAIL odd_data got=%h exp=abcd", data); end
    total++; if (data_le !== 16'hCDAB) begin bad++; $display("FAIL odd_data_le got=%h exp=cdab", data_le); end
    tick();
  endtask

  task automatic test_early_request();
    int idle_at, ack_at;
    logic [15:0] exp_d;
    rst = 1'b1;
    req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    addr = 23'h000002;
    req  = 1'b1;
    exp_d = {flash_byte(23'h000002), flash_byte(23'h000003)};
    idle_at = -1;
    ack_at  = -1;
    for (int c = 3; c <= 40; c++) begin
      tick();
      if (busy == 1'b0 && idle_at < 0) idle_at = c;
      if (ack == req && ack_at < 0) ack_at = c;
    end
    total++; if (idle_at != int'(RC + RR))
      begin bad++; $display("FAIL early_idle got=%0d exp=%0d", idle_at, RC + RR); end
    total++; if (ack_at != int'(RC + RR) + LAT)
      begin bad++; $display("FAIL early_ack got=%0d exp=%0d", ack_at, int'(RC + RR) + LAT); end
    total++; if (data !== exp_d) begin bad++; $display("FAIL early_data got=%h exp=%h", data, exp_d); end
  endtask

  task automatic test_mid_reset();
    int waited, lat;
    logic [15:0] exp_d;
    addr = 23'h000010;
    req  = ~req;
    for (int c = 1; c <= int'(AC) + 2; c++) tick();
    total++; if (fl_addr !== 23'h000011 || ce_n !== 1'b0)
      begin bad++; $display("FAIL mid_in_rdlo got a=%h ce=%0b exp a=000011 ce=0", fl_addr, ce_n); end
    rst = 1'b1;
    req = 1'b0;
    tick();
    total++; if (ce_n !== 1'b1 || oe_n !== 1'b1)
      begin bad++; $display("FAIL mid_ce_oe got=%0b%0b exp=11", ce_n, oe_n); end
    total++; if (rst_n !== 1'b0) begin bad++; $display("FAIL mid_fl_rst got=%0b exp=0", rst_n); end
    total++; if (ack !== 1'b0)   begin bad++; $display("FAIL mid_ack got=%0b exp=0", ack); end
    rst = 1'b0;
    waited = 0;
    while (busy !== 1'b0 && waited < 40) begin tick(); waited++; end
    total++; if (waited != int'(RC + RR))
      begin bad++; $display("FAIL mid_recover got=%0d exp=%0d", waited, RC + RR); end
    addr  = 23'h000020;
    req   = 1'b1;
    exp_d = {flash_byte(23'h000020), flash_byte(23'h000021)};
    lat = 0;
    while (ack !== req && lat < 40) begin tick(); lat++; end
    total++; if (lat != LAT) begin bad++; $display("FAIL mid_fresh_lat got=%0d exp=%0d", lat, LAT); end
    total++; if (data !== exp_d) begin bad++; $display("FAIL mid_fresh_data got=%h exp=%h", data, exp_d); end
    tick();
  endtask

  task automatic test_back_to_back();
    int prev, waited;
    logic [22:0] a;
    logic [15:0] exp_d;
    prev = -1;
    for (int i = 0; i < 16; i++) begin
      a     = 23'h000100 + 23'(2 * i);
      exp_d = {flash_byte(a), flash_byte(a + 23'd1)};
      addr  = a;
      req   = ~req;
      waited = 0;
      while (ack !== req && waited < 30) begin tick(); waited++; end
      total++; if (ack !== req)
        begin bad++; $display("FAIL b2b_timeout i=%0d got ack=%0b exp=%0b", i, ack, req); end
      total++; if (data !== exp_d)
        begin bad++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, data, exp_d); end
      total++; if (data_le !== {exp_d[7:0], exp_d[15:8]})
        begin bad++; $display("FAIL b2b_data_le i=%0d got=%h exp=%h", i, data_le, {exp_d[7:0], exp_d[15:8]}); end
      if (prev >= 0) begin
        total++; if (cyc - prev < 11)
          begin bad++; $display("FAIL b2b_spacing i=%0d got=%0d exp>=11", i, cyc - prev); end
      end
      prev = cyc;
      tick();
    end
    total++; if (tie_bad !== 1'b0)
      begin bad++; $display("FAIL ties_held got=%0b exp=0", tie_bad); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_odd_addr();
    test_early_request();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
